// File: rtl/mem_arbiter_mc_pkg.sv
// Shared types and constants for the multi-channel byte-serial RAM controller.
package mem_arbiter_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_READ      = 2'd1,
        ST_WRITE     = 2'd2,
        ST_WRITE_GAP = 2'd3
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int          BYTE_W      = 8;
    localparam int          DEF_ADDR_W  = 32;
    localparam logic [31:0] DEF_IO_ADDR = 32'h0003_0000;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational picker: first pending channel after ptr wins, one-hot grant plus index.
// Zero latency; no backpressure (pure function of its inputs).
module mem_arb_pick #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 1
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    // Scan farthest-first so the channel nearest after ptr overwrites the rest.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int off = NUM_CH; off >= 1; off--) begin
            if (pending[(int'(ptr) + off) % NUM_CH]) begin
                grant                                 = '0;
                grant[(int'(ptr) + off) % NUM_CH]     = 1'b1;
                grant_idx                             = CH_W'((int'(ptr) + off) % NUM_CH);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_mc.sv
// NUM_CH clients share one byte-serial RAM port; read done n cycles after grant edge, writes paced at IO_ADDR.
// One-entry buffer per channel (req_ready = buffer free); MEM_ARB_RR_EN selects round-robin over fixed priority.
module mem_arbiter_mc
    import mem_arbiter_mc_pkg::*;
#(
    parameter int                NUM_CH    = 2,
    parameter int                MAX_BYTES = 4,
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] IO_ADDR   = ADDR_W'(DEF_IO_ADDR)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 rdy,
    input  logic                                 io_buffer_full_signal,
    input  logic [BYTE_W-1:0]                    mem_din,
    output logic                                 mem_wr,
    output logic [ADDR_W-1:0]                    mem_a,
    output logic [BYTE_W-1:0]                    mem_dout,
    input  logic                                 flush,
    input  logic [NUM_CH-1:0]                    req_valid,
    output logic [NUM_CH-1:0]                    req_ready,
    input  logic [NUM_CH-1:0]                    req_wr,
    input  logic [3*NUM_CH-1:0]                  req_len,
    input  logic [ADDR_W*NUM_CH-1:0]             req_addr,
    input  logic [BYTE_W*MAX_BYTES*NUM_CH-1:0]   req_wdata,
    output logic [NUM_CH-1:0]                    done,
    output logic [BYTE_W*MAX_BYTES-1:0]          rdata,
    output logic                                 busy
);

    localparam int DATA_W = BYTE_W * MAX_BYTES;
    localparam int LEN_W  = $clog2(MAX_BYTES + 1);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Pending request buffers
    logic [NUM_CH-1:0] pend, pend_d, p_wr, accept, avail, grant, flush_clr;
    logic [LEN_W-1:0]  p_len   [NUM_CH];
    logic [ADDR_W-1:0] p_addr  [NUM_CH];
    logic [DATA_W-1:0] p_wdata [NUM_CH];
    logic [LEN_W-1:0]  in_len  [NUM_CH];

    // Granted transaction
    logic [CH_W-1:0]   g_idx, rr_ptr, cur_ch;
    logic              start, sel_wr, cur_io;
    logic [LEN_W-1:0]  sel_len, cur_len, cnt, cnt_d;
    logic [ADDR_W-1:0] sel_addr, cur_addr;
    logic [DATA_W-1:0] sel_wdata, cur_wdata, rbuf, rbuf_d;
    state_t            state, state_d;

    // Next values of the registered RAM/client outputs
    logic              wr_d;
    logic [ADDR_W-1:0] a_d;
    logic [BYTE_W-1:0] dout_d;
    logic [NUM_CH-1:0] done_d;
    logic [DATA_W-1:0] rdata_d;

    assign req_ready = ~pend;
    assign busy      = (state != ST_IDLE);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_len[3*i +: 3] == 3'd0 || int'(req_len[3*i +: 3]) > MAX_BYTES) begin
                in_len[i] = LEN_W'(MAX_BYTES);
            end else begin
                in_len[i] = LEN_W'(req_len[3*i +: 3]);
            end
            accept[i]    = req_valid[i] & ~pend[i] & ~flush;
            flush_clr[i] = flush & pend[i] & (p_wr[i] == OP_READ);
        end
    end

    // Accepted requests are visible to the picker in the same cycle (bypass).
    assign avail = pend | accept;
    assign start = (state == ST_IDLE) && !flush && (|avail);

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= CH_W'(NUM_CH - 1);
        end else if (rdy && start) begin
            rr_ptr <= g_idx;
        end
    end
`else
    // Searching from NUM_CH-1 onwards is plain lowest-index priority.
    assign rr_ptr = CH_W'(NUM_CH - 1);
`endif

    mem_arb_pick #(
        .NUM_CH    (NUM_CH),
        .CH_W      (CH_W)
    ) u_pick (
        .pending   (avail),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (g_idx)
    );

    always_comb begin
        sel_wr    = pend[g_idx] ? p_wr[g_idx]    : req_wr[g_idx];
        sel_len   = pend[g_idx] ? p_len[g_idx]   : in_len[g_idx];
        sel_addr  = pend[g_idx] ? p_addr[g_idx]  : req_addr[ADDR_W*g_idx +: ADDR_W];
        sel_wdata = pend[g_idx] ? p_wdata[g_idx] : req_wdata[DATA_W*g_idx +: DATA_W];
        pend_d    = (pend & ~flush_clr) | accept;
        if (start) begin
            pend_d = pend_d & ~grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rdy) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept[i]) begin
                    p_wr[i]    <= req_wr[i];
                    p_len[i]   <= in_len[i];
                    p_addr[i]  <= req_addr[ADDR_W*i +: ADDR_W];
                    p_wdata[i] <= req_wdata[DATA_W*i +: DATA_W];
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pend      <= '0;
            rbuf      <= '0;
            cur_ch    <= '0;
            cur_len   <= '0;
            cur_addr  <= '0;
            cur_wdata <= '0;
            cur_io    <= 1'b0;
        end else if (rdy) begin
            state <= state_d;
            cnt   <= cnt_d;
            pend  <= pend_d;
            rbuf  <= rbuf_d;
            if (start) begin
                cur_ch    <= g_idx;
                cur_len   <= sel_len;
                cur_addr  <= sel_addr;
                cur_wdata <= sel_wdata;
                cur_io    <= (sel_addr == IO_ADDR);
            end
        end
    end

    // Next state; cnt is the next byte index to address or write.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (sel_wr == OP_WRITE) begin
                        state_d = ST_WRITE;
                        cnt_d   = '0;
                        if (!io_buffer_full_signal) begin
                            cnt_d = LEN_W'(1);
                            if (sel_addr == IO_ADDR) begin
                                state_d = ST_WRITE_GAP;
                            end
                        end
                    end else begin
                        state_d = ST_READ;
                        cnt_d   = LEN_W'(1);
                    end
                end
            end
            ST_READ: begin
                if (flush || cnt == cur_len) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_WRITE: begin
                if (!io_buffer_full_signal) begin
                    if (cnt == cur_len) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt + 1'b1;
                        if (cur_io) begin
                            state_d = ST_WRITE_GAP;
                        end
                    end
                end
            end
            ST_WRITE_GAP: state_d = ST_WRITE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values
    always_comb begin
        wr_d    = 1'b0;
        a_d     = '0;
        dout_d  = '0;
        done_d  = '0;
        rdata_d = '0;
        rbuf_d  = rbuf;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    rbuf_d = '0;
                    if (sel_wr == OP_WRITE) begin
                        if (!io_buffer_full_signal) begin
                            wr_d   = 1'b1;
                            a_d    = sel_addr;
                            dout_d = sel_wdata[BYTE_W-1:0];
                        end
                    end else begin
                        a_d = sel_addr;
                    end
                end
            end
            ST_READ: begin
                if (!flush) begin
                    rbuf_d[BYTE_W*(int'(cnt) - 1) +: BYTE_W] = mem_din;
                    if (cnt == cur_len) begin
                        done_d[cur_ch] = 1'b1;
                        rdata_d        = rbuf_d;
                    end else begin
                        a_d = cur_addr + ADDR_W'(cnt);
                    end
                end
            end
            ST_WRITE: begin
                if (!io_buffer_full_signal) begin
                    if (cnt == cur_len) begin
                        done_d[cur_ch] = 1'b1;
                    end else begin
                        wr_d   = 1'b1;
                        a_d    = cur_addr + ADDR_W'(cnt);
                        dout_d = cur_wdata[BYTE_W*int'(cnt) +: BYTE_W];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wr   <= 1'b0;
            mem_a    <= '0;
            mem_dout <= '0;
            done     <= '0;
            rdata    <= '0;
        end else if (rdy) begin
            mem_wr   <= wr_d;
            mem_a    <= a_d;
            mem_dout <= dout_d;
            done     <= done_d;
            rdata    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_mc.sv
// Directed bench for mem_arbiter_mc (NUM_CH=2, MAX_BYTES=4) with an async-read RAM model.
module tb_mem_arbiter_mc;

    logic        clk = 1'b0;
    logic        rst, rdy, io_full, flush;
    logic [7:0]  mem_din, mem_dout;
    logic        mem_wr;
    logic [31:0] mem_a;
    logic [1:0]  req_valid, req_ready, req_wr, done;
    logic [5:0]  req_len;
    logic [63:0] req_addr, req_wdata;
    logic [31:0] rdata;
    logic        busy;
    logic [7:0]  ram [4096];

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0]  alt_done;
    logic [31:0] alt_addr, alt_rdata;

    always #5 clk = ~clk;

    assign mem_din = ram[mem_a[11:0]];

    mem_arbiter_mc dut (
        .clk                   (clk),
        .rst                   (rst),
        .rdy                   (rdy),
        .io_buffer_full_signal (io_full),
        .mem_din               (mem_din),
        .mem_wr                (mem_wr),
        .mem_a                 (mem_a),
        .mem_dout              (mem_dout),
        .flush                 (flush),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_wr                (req_wr),
        .req_len               (req_len),
        .req_addr              (req_addr),
        .req_wdata             (req_wdata),
        .done                  (done),
        .rdata                 (rdata),
        .busy                  (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int ch, input logic wr, input logic [2:0] len,
                           input logic [31:0] addr, input logic [31:0] wdata);
        req_wr[ch]            = wr;
        req_len[3*ch +: 3]    = len;
        req_addr[32*ch +: 32] = addr;
        req_wdata[32*ch +: 32] = wdata;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
        ram[12'h104] = 8'h55; ram[12'h105] = 8'h66;
        ram[12'hFFF] = 8'hA5; ram[12'h000] = 8'h5A;
        rst = 1'b1; rdy = 1'b1; io_full = 1'b0; flush = 1'b0;
        req_valid = '0; req_wr = '0; req_len = '0; req_addr = '0; req_wdata = '0;
        tick(); tick();
        chk("rst_ready", req_ready, 2'b11);
        chk("rst_done", done, 2'b00);
        chk("rst_wr", mem_wr, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_a", mem_a, 32'h0);
        chk("rst_dout", mem_dout, 8'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        tick();

        // Fetch: ch0 read 4 bytes at 0x100
        set_req(0, 1'b0, 3'd4, 32'h100, 32'h0); req_valid = 2'b01;
        tick();
        chk("t1_a0", mem_a, 32'h100); chk("t1_busy", busy, 1'b1); chk("t1_ready", req_ready, 2'b11);
        req_valid = '0;
        tick(); chk("t1_a1", mem_a, 32'h101);
        tick(); tick(); chk("t1_a3", mem_a, 32'h103); chk("t1_nodone", done, 2'b00);
        tick(); chk("t1_done", done, 2'b01); chk("t1_rdata", rdata, 32'h44332211); chk("t1_a_idle", mem_a, 32'h0);
        tick(); chk("t1_pulse", done, 2'b00); chk("t1_idle", busy, 1'b0);

        // Simultaneous ch0 read / ch1 write: ch0 first
        set_req(0, 1'b0, 3'd2, 32'h104, 32'h0);
        set_req(1, 1'b1, 3'd1, 32'h200, 32'h77);
        req_valid = 2'b11;
        tick(); chk("t2_a0", mem_a, 32'h104); chk("t2_ready", req_ready, 2'b01);
        req_valid = '0;
        tick(); chk("t2_a1", mem_a, 32'h105); chk("t2_ready1", req_ready, 2'b01);
        tick(); chk("t2_done0", done, 2'b01); chk("t2_rdata", rdata, 32'h00006655);
        tick(); chk("t2_wr", mem_wr, 1'b1); chk("t2_wa", mem_a, 32'h200); chk("t2_wd", mem_dout, 8'h77);
        tick(); chk("t2_done1", done, 2'b10); chk("t2_wr_off", mem_wr, 1'b0);
        tick();

        // Flush during ch1 read with ch0 read pending
        set_req(1, 1'b0, 3'd4, 32'h100, 32'h0); req_valid = 2'b10;
        tick(); chk("t3_a0", mem_a, 32'h100);
        set_req(0, 1'b0, 3'd1, 32'h104, 32'h0); req_valid = 2'b01;
        tick(); chk("t3_ready", req_ready, 2'b10);
        req_valid = '0;
        tick(); chk("t3_a2", mem_a, 32'h102);
        flush = 1'b1;
        tick(); chk("t3_nodone", done, 2'b00); chk("t3_idle", busy, 1'b0); chk("t3_rdy", req_ready, 2'b11);
        flush = 1'b0;
        tick(); chk("t3_stay", busy, 1'b0); chk("t3_nodone2", done, 2'b00);

        // IO store with UART full for three cycles
        io_full = 1'b1;
        set_req(1, 1'b1, 3'd1, 32'h30000, 32'h41); req_valid = 2'b10;
        tick(); chk("t4_s0", mem_wr, 1'b0); chk("t4_busy", busy, 1'b1);
        req_valid = '0;
        tick(); chk("t4_s1", mem_wr, 1'b0);
        tick(); chk("t4_s2", mem_wr, 1'b0);
        io_full = 1'b0;
        tick(); chk("t4_wr", mem_wr, 1'b1); chk("t4_a", mem_a, 32'h30000); chk("t4_d", mem_dout, 8'h41);
        tick(); chk("t4_gap", mem_wr, 1'b0); chk("t4_gapdone", done, 2'b00);
        tick(); chk("t4_done", done, 2'b10);
        tick();

        // Two-byte store, little-endian
        set_req(0, 1'b1, 3'd2, 32'h200, 32'h0000BEEF); req_valid = 2'b01;
        tick(); chk("t5_a0", mem_a, 32'h200); chk("t5_d0", mem_dout, 8'hEF); chk("t5_w0", mem_wr, 1'b1);
        req_valid = '0;
        tick(); chk("t5_a1", mem_a, 32'h201); chk("t5_d1", mem_dout, 8'hBE);
        tick(); chk("t5_done", done, 2'b01); chk("t5_wroff", mem_wr, 1'b0);
        tick();

        // Length 0 means MAX_BYTES
        set_req(0, 1'b0, 3'd0, 32'h100, 32'h0); req_valid = 2'b01;
        tick(); req_valid = '0;
        tick(); tick(); tick(); chk("len0_nodone", done, 2'b00);
        tick(); chk("len0_done", done, 2'b01); chk("len0_rdata", rdata, 32'h44332211);
        tick();

        // Address wraps modulo 2^32
        set_req(1, 1'b0, 3'd2, 32'hFFFF_FFFF, 32'h0); req_valid = 2'b10;
        tick(); chk("wrap_a0", mem_a, 32'hFFFF_FFFF); req_valid = '0;
        tick(); chk("wrap_a1", mem_a, 32'h0);
        tick(); chk("wrap_done", done, 2'b10); chk("wrap_rdata", rdata, 32'h00005AA5);
        tick();

        // rdy low mid-read holds everything
        set_req(0, 1'b0, 3'd4, 32'h100, 32'h0); req_valid = 2'b01;
        tick(); req_valid = '0;
        tick(); chk("rdy_a1", mem_a, 32'h101);
        rdy = 1'b0;
        tick(); tick(); chk("rdy_hold_a", mem_a, 32'h101); chk("rdy_hold_busy", busy, 1'b1);
        rdy = 1'b1;
        tick(); chk("rdy_a2", mem_a, 32'h102);
        tick(); tick(); chk("rdy_done", done, 2'b01); chk("rdy_rdata", rdata, 32'h44332211);
        tick();

        // Both channels continuously requesting
`ifdef MEM_ARB_RR_EN
        alt_done = 2'b10; alt_addr = 32'h101; alt_rdata = 32'h22;
`else
        alt_done = 2'b01; alt_addr = 32'h100; alt_rdata = 32'h11;
`endif
        set_req(0, 1'b0, 3'd1, 32'h100, 32'h0);
        set_req(1, 1'b0, 3'd1, 32'h101, 32'h0);
        req_valid = 2'b11;
        tick(); chk("arb_g0", mem_a, 32'h100);
        tick(); chk("arb_d0", done, 2'b01);
        tick(); chk("arb_g1", mem_a, alt_addr);
        tick(); chk("arb_d1", done, alt_done); chk("arb_r1", rdata, alt_rdata);
        tick(); tick(); chk("arb_d2", done, 2'b01);
        tick(); tick(); chk("arb_d3", done, alt_done);
        req_valid = '0;
        repeat (6) tick();
        chk("arb_drain_busy", busy, 1'b0); chk("arb_drain_ready", req_ready, 2'b11);

        // Reset mid-transaction: no done
        set_req(0, 1'b0, 3'd4, 32'h100, 32'h0); req_valid = 2'b01;
        tick(); chk("mrst_a0", mem_a, 32'h100); req_valid = '0;
        rst = 1'b1;
        tick(); chk("mrst_busy", busy, 1'b0); chk("mrst_a", mem_a, 32'h0);
        rst = 1'b0;
        tick(); chk("mrst_done", done, 2'b00); chk("mrst_ready", req_ready, 2'b11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
